uart_rx: RTL and testbench

UART receiver; the downstream partner of uart_tx. It consumes a serial line (idle high, 1 start bit, DW data bits LSB-first, 1 stop bit) and delivers parallel bytes on a valid/ready output. It reports framing errors and overruns. The baud timing matches uart_tx: one bit lasts BAUD_COUNTER clock cycles, and the receiver samples each bit once, near its midpoint.

---
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM,
// valid/ready byte output with framing-error and overrun pulses.
module uart_rx #(
    parameter int  DW           = 8,
    parameter real CLOCK        = 100e6,
    parameter int  BAUD_RATE    = 20000000,
    parameter int  BAUD_COUNTER = $rtoi(CLOCK / BAUD_RATE),
    parameter int  BRW          = $clog2(BAUD_COUNTER + 1),
    parameter int  HALF         = BAUD_COUNTER / 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          Rx,
    input  logic          ready_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          frame_err_o,
    output logic          overrun_o,
    output logic          busy_o
);

    localparam int IW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [BRW-1:0] CNT_HALF = BRW'(HALF);
    localparam logic [BRW-1:0] CNT_LAST = BRW'(BAUD_COUNTER - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(DW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    logic          rx_s;

    state_t        state_q, state_d;
    logic [BRW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          busy_q;
    logic [DW:0]   shift_ext;

    assign rx_s      = sync2_q;
    // New bit enters at the MSB; after DW shifts the first bit sits at bit 0.
    assign shift_ext = {rx_s, shift_q};

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= Rx;
            sync2_q <= sync1_q;
        end
    end

    // Next-state, bit timing, shift register and output handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~ready_i;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;   // start bit did not hold: glitch
                    end else begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = shift_ext[DW:1];
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        // Unconsumed byte lost unless it is accepted this cycle.
                        ovr_d   = valid_q & ~ready_i;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // Hold off during a break so a low line cannot restart reception.
                if (rx_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: serial frames generated from the line protocol,
// expected events queued at stimulus time, popped by an independent monitor.
module tb_uart_rx;

    localparam int DW   = 8;
    localparam int BC   = 100_000_000 / 20_000_000;      // cycles per bit
    localparam int FULL = 10 * BC;                        // cycles per frame
    localparam int LAT  = 3 + BC / 2 + (DW + 1) * BC;     // start edge -> decision edge

    logic          clk_i   = 1'b0;
    logic          rst_i   = 1'b1;
    logic          Rx      = 1'b1;
    logic          ready_i = 1'b1;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          frame_err_o;
    logic          overrun_o;
    logic          busy_o;

    uart_rx dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .Rx          (Rx),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef enum int {EV_DATA = 0, EV_FERR = 1, EV_OVR = 2} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [7:0]  data;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, got, $time);
        end
    endtask

    task automatic push_ev(input ev_kind_t kind, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor side of the scoreboard: each observed event consumes one entry.
    task automatic sb_pop(input ev_kind_t kind, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got event %0d data %0h, required none at %0t", kind, d, $time);
        end else begin
            e = exp_q.pop_front();
            check("sb_kind", 32'(kind), 32'(e.kind));
            if (e.kind == EV_DATA && kind == EV_DATA) begin
                check("sb_data", 32'(d), 32'(e.data));
            end
        end
    endtask

    // Serial line model: start bit, DW data bits LSB first, stop bit, BC cycles each.
    // Called on a falling edge; drives the first ncyc cycles of the frame.
    task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input int ncyc);
        logic [9:0] line;
        line = {stop_bit, d, 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            Rx = line[c / BC];
            @(negedge clk_i);
        end
    endtask

    // Monitor: samples just after the falling edge so the driven inputs have settled.
    always begin
        @(negedge clk_i);
        #2;
        if (!rst_i) begin
            if (frame_err_o) sb_pop(EV_FERR, 8'h00);
            if (overrun_o)   sb_pop(EV_OVR, 8'h00);
            if (valid_o && ready_i) sb_pop(EV_DATA, data_o);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic       err;
        int         waited;

        // Reset state
        rst_i = 1'b1; Rx = 1'b1; ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("reset_outputs", {data_o, valid_o, frame_err_o, overrun_o, busy_o}, 32'h0);
        rst_i = 1'b0;

        // Idle line: nothing happens
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            check("idle_outputs", {data_o, valid_o, frame_err_o, overrun_o, busy_o}, 32'h0);
        end

        // Single frame 0xAA with exact latency
        push_ev(EV_DATA, 8'hAA);
        drive_frame(8'hAA, 1'b1, FULL);
        repeat (LAT - FULL) @(negedge clk_i);
        check("single_valid_before", valid_o, 1'b0);
        @(negedge clk_i);
        check("single_valid_at_lat", valid_o, 1'b1);
        check("single_data", data_o, 8'hAA);
        @(negedge clk_i);
        check("single_valid_one_cycle", valid_o, 1'b0);
        check("single_no_pulses", {frame_err_o, overrun_o}, 2'b00);
        repeat (5) @(negedge clk_i);

        // Back-to-back frames
        push_ev(EV_DATA, 8'hAA);
        push_ev(EV_DATA, 8'hF0);
        drive_frame(8'hAA, 1'b1, FULL);
        drive_frame(8'hF0, 1'b1, FULL);
        Rx = 1'b1;
        repeat (10) @(negedge clk_i);

        // Glitch: one low cycle
        Rx = 1'b0;
        @(negedge clk_i);
        Rx = 1'b1;
        repeat (2) @(negedge clk_i);
        check("glitch_busy_rise", busy_o, 1'b1);
        repeat (3) @(negedge clk_i);
        check("glitch_busy_fall", busy_o, 1'b0);
        repeat (20) @(negedge clk_i);
        check("glitch_no_valid", valid_o, 1'b0);

        // Framing error, line held low afterwards
        push_ev(EV_FERR, 8'h00);
        drive_frame(8'h55, 1'b0, FULL);
        repeat (LAT - FULL) @(negedge clk_i);
        check("ferr_before", frame_err_o, 1'b0);
        @(negedge clk_i);
        check("ferr_pulse", frame_err_o, 1'b1);
        check("ferr_no_valid", valid_o, 1'b0);
        @(negedge clk_i);
        check("ferr_one_cycle", frame_err_o, 1'b0);
        repeat (28) @(negedge clk_i);
        check("ferr_busy_held", busy_o, 1'b1);
        Rx = 1'b1;
        repeat (2) @(negedge clk_i);
        check("ferr_busy_sync", busy_o, 1'b1);
        @(negedge clk_i);
        check("ferr_busy_release", busy_o, 1'b0);
        repeat (3) @(negedge clk_i);
        push_ev(EV_DATA, 8'h3C);
        drive_frame(8'h3C, 1'b1, FULL);
        Rx = 1'b1;
        repeat (10) @(negedge clk_i);

        // Overrun with consumer stalled
        ready_i = 1'b0;
        push_ev(EV_OVR, 8'h00);
        push_ev(EV_DATA, 8'h22);
        drive_frame(8'h11, 1'b1, FULL);
        drive_frame(8'h22, 1'b1, FULL);
        Rx = 1'b1;
        repeat (LAT - FULL) @(negedge clk_i);
        @(negedge clk_i);
        check("ovr_pulse", overrun_o, 1'b1);
        check("ovr_valid", valid_o, 1'b1);
        check("ovr_data", data_o, 8'h22);
        @(negedge clk_i);
        check("ovr_one_cycle", overrun_o, 1'b0);
        ready_i = 1'b1;
        @(negedge clk_i);
        check("ovr_drained", valid_o, 1'b0);
        repeat (5) @(negedge clk_i);

        // Acceptance coinciding with a new completion: no overrun
        ready_i = 1'b0;
        push_ev(EV_DATA, 8'h11);
        push_ev(EV_DATA, 8'h22);
        drive_frame(8'h11, 1'b1, FULL);
        drive_frame(8'h22, 1'b1, FULL);
        Rx = 1'b1;
        repeat (LAT - FULL) @(negedge clk_i);
        ready_i = 1'b1;
        check("accept_old_data", data_o, 8'h11);
        @(negedge clk_i);
        check("accept_new_valid", valid_o, 1'b1);
        check("accept_new_data", data_o, 8'h22);
        check("accept_no_overrun", overrun_o, 1'b0);
        @(negedge clk_i);
        check("accept_drained", valid_o, 1'b0);
        repeat (5) @(negedge clk_i);

        // Reset in the middle of data bit 4
        drive_frame(8'h81, 1'b1, BC * 5 + BC / 2);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midreset_busy", busy_o, 1'b0);
        check("midreset_valid", valid_o, 1'b0);
        rst_i = 1'b0;
        Rx = 1'b1;
        repeat (10) @(negedge clk_i);
        push_ev(EV_DATA, 8'h81);
        drive_frame(8'h81, 1'b1, FULL);
        Rx = 1'b1;
        repeat (10) @(negedge clk_i);

        // Randomized frames with occasional framing errors and random gaps
        for (int n = 0; n < 40; n++) begin
            d   = 8'($urandom);
            err = ($urandom_range(0, 7) == 0);
            if (err) push_ev(EV_FERR, 8'h00);
            else     push_ev(EV_DATA, d);
            drive_frame(d, !err, FULL);
            if (err) begin
                repeat ($urandom_range(0, 10)) @(negedge clk_i);
                Rx = 1'b1;
                repeat (4) @(negedge clk_i);
            end else begin
                Rx = 1'b1;
                repeat ($urandom_range(0, 3)) @(negedge clk_i);
            end
        end

        // Every expected event must have been observed
        waited = 0;
        while (exp_q.size() > 0 && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
        check("sb_drain_remaining", exp_q.size(), 0);
        repeat (5) @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
